// File: rtl/tri_span_gen_pkg.sv
// Shared definitions for the flat-base triangle span generator.
package tri_span_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_EMIT,
        ST_ADVANCE
    } state_t;

    // Extra bits the Bresenham error term needs beyond the coordinate width.
    localparam int ERR_GUARD_BITS = 2;

    function automatic int err_width(input int coord_width);
        return coord_width + ERR_GUARD_BITS;
    endfunction

endpackage

// File: rtl/tri_span_gen_edge_walker.sv
// One Bresenham edge from the apex towards a base endpoint; each step request
// advances one iteration until the edge moves onto the next scanline.
module edge_walker
    import tri_span_gen_pkg::*;
#(
    parameter int COORD_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_init,
    input  logic                          i_clear,
    input  logic                          i_step,
    input  logic signed [COORD_WIDTH-1:0] i_x0,
    input  logic signed [COORD_WIDTH-1:0] i_y0,
    input  logic signed [COORD_WIDTH-1:0] i_x1,
    input  logic signed [COORD_WIDTH-1:0] i_y1,
    output logic signed [COORD_WIDTH-1:0] o_x,
    output logic signed [COORD_WIDTH-1:0] o_y,
    output logic                          o_stopped
);

    localparam int EW = err_width(COORD_WIDTH);
    localparam logic [COORD_WIDTH-1:0] C_ONE = COORD_WIDTH'(1);

    logic signed [COORD_WIDTH-1:0] r_x, r_y;
    logic signed [EW-1:0]          r_dx, r_dy, r_err;
    logic                          r_sx_neg, r_sy_neg, r_stop;

    logic signed [EW-1:0]          w_x0e, w_x1e, w_y0e, w_y1e;
    logic signed [EW-1:0]          w_ddx, w_ddy, w_dx_init, w_dy_init;
    logic signed [EW:0]            w_e2, w_dx_e, w_dy_e;
    logic signed [EW-1:0]          w_err_nxt;
    logic                          w_xstep, w_ystep;

    // Edge setup: dx = |x1-x0|, dy = -|y1-y0|, step directions from the signs.
    always_comb begin
        w_x0e     = {{(EW-COORD_WIDTH){i_x0[COORD_WIDTH-1]}}, i_x0};
        w_x1e     = {{(EW-COORD_WIDTH){i_x1[COORD_WIDTH-1]}}, i_x1};
        w_y0e     = {{(EW-COORD_WIDTH){i_y0[COORD_WIDTH-1]}}, i_y0};
        w_y1e     = {{(EW-COORD_WIDTH){i_y1[COORD_WIDTH-1]}}, i_y1};
        w_ddx     = w_x1e - w_x0e;
        w_ddy     = w_y1e - w_y0e;
        w_dx_init = w_ddx[EW-1] ? -w_ddx : w_ddx;
        w_dy_init = w_ddy[EW-1] ? w_ddy : -w_ddy;
    end

    // One Bresenham iteration evaluated at one extra bit of headroom.
    always_comb begin
        w_e2      = {r_err, 1'b0};
        w_dx_e    = {r_dx[EW-1], r_dx};
        w_dy_e    = {r_dy[EW-1], r_dy};
        w_xstep   = (w_e2 >= w_dy_e);
        w_ystep   = (w_e2 <= w_dx_e);
        w_err_nxt = r_err;
        if (w_xstep) w_err_nxt = w_err_nxt + r_dy;
        if (w_ystep) w_err_nxt = w_err_nxt + r_dx;
    end

    // Stopped includes the iteration that is moving y right now, so the
    // controller can leave ADVANCE on that same edge.
    assign o_stopped = r_stop | (i_step & ~r_stop & w_ystep);
    assign o_x       = r_x;
    assign o_y       = r_y;

    // Walker state: load on init, iterate while stepping and not yet stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_stop   <= 1'b0;
        end else if (i_init) begin
            r_x      <= i_x0;
            r_y      <= i_y0;
            r_dx     <= w_dx_init;
            r_dy     <= w_dy_init;
            r_err    <= w_dx_init + w_dy_init;
            r_sx_neg <= w_ddx[EW-1];
            r_sy_neg <= w_ddy[EW-1];
            r_stop   <= 1'b0;
        end else begin
            if (i_clear) r_stop <= 1'b0;
            if (i_step && !r_stop) begin
                r_err <= w_err_nxt;
                if (w_xstep) r_x <= r_sx_neg ? r_x - C_ONE : r_x + C_ONE;
                if (w_ystep) begin
                    r_y    <= r_sy_neg ? r_y - C_ONE : r_y + C_ONE;
                    r_stop <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tri_span_gen.sv
// Flat-base triangle rasterizer: walks both edges from the apex and hands one
// horizontal span per scanline to a downstream line drawer.
module tri_span_gen
    import tri_span_gen_pkg::*;
#(
    parameter int COORD_WIDTH = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start,
    input  logic signed [COORD_WIDTH-1:0] xa,
    input  logic signed [COORD_WIDTH-1:0] ya,
    input  logic signed [COORD_WIDTH-1:0] yb,
    input  logic signed [COORD_WIDTH-1:0] xl,
    input  logic signed [COORD_WIDTH-1:0] xr,
    output logic signed [COORD_WIDTH-1:0] span_x0,
    output logic signed [COORD_WIDTH-1:0] span_x1,
    output logic signed [COORD_WIDTH-1:0] span_y,
    output logic                          span_valid,
    input  logic                          span_ready,
    output logic                          busy,
    output logic                          done
);

    state_t r_state, w_next;
    logic signed [COORD_WIDTH-1:0] r_xa, r_ya, r_yb, r_xl, r_xr;
    logic r_done;

    logic w_init, w_clear, w_step, w_last_xfer, w_last_row;
    logic signed [COORD_WIDTH-1:0] w_lx, w_ly, w_rx, w_ry;
    logic w_lstop, w_rstop;

    edge_walker #(.COORD_WIDTH(COORD_WIDTH)) u_left (
        .clk(clk_in), .rst(rst_in), .i_init(w_init), .i_clear(w_clear),
        .i_step(w_step), .i_x0(r_xa), .i_y0(r_ya), .i_x1(r_xl), .i_y1(r_yb),
        .o_x(w_lx), .o_y(w_ly), .o_stopped(w_lstop)
    );

    edge_walker #(.COORD_WIDTH(COORD_WIDTH)) u_right (
        .clk(clk_in), .rst(rst_in), .i_init(w_init), .i_clear(w_clear),
        .i_step(w_step), .i_x0(r_xa), .i_y0(r_ya), .i_x1(r_xr), .i_y1(r_yb),
        .o_x(w_rx), .o_y(w_ry), .o_stopped(w_rstop)
    );

    // Both walkers sit on the same scanline whenever a span is presented.
    assign w_last_row = (w_ly == r_yb) && (w_ry == r_yb);
    assign span_valid = (r_state == ST_EMIT);
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;

    // State register, accepted-start input capture and done pulse.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
            r_xa    <= '0;
            r_ya    <= '0;
            r_yb    <= '0;
            r_xl    <= '0;
            r_xr    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_last_xfer;
            if (r_state == ST_IDLE && start) begin
                r_xa <= xa;
                r_ya <= ya;
                r_yb <= yb;
                r_xl <= xl;
                r_xr <= xr;
            end
        end
    end

    // Next-state logic and walker control strobes.
    always_comb begin
        w_next      = r_state;
        w_init      = 1'b0;
        w_clear     = 1'b0;
        w_step      = 1'b0;
        w_last_xfer = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_INIT;
            ST_INIT: begin
                w_init = 1'b1;
                w_next = ST_EMIT;
            end
            ST_EMIT: begin
                if (span_ready) begin
                    if (w_last_row) begin
                        w_last_xfer = 1'b1;
                        w_next      = ST_IDLE;
                    end else begin
                        w_clear = 1'b1;
                        w_next  = ST_ADVANCE;
                    end
                end
            end
            ST_ADVANCE: begin
                w_step = 1'b1;
                if (w_lstop && w_rstop) w_next = ST_EMIT;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Span fields: walker x ordered, except the base row which uses the exact endpoints.
    always_comb begin
        span_x0 = '0;
        span_x1 = '0;
        span_y  = '0;
        if (r_state == ST_EMIT) begin
            span_y = w_ly;
            if (w_last_row) begin
                span_x0 = (r_xl <= r_xr) ? r_xl : r_xr;
                span_x1 = (r_xl <= r_xr) ? r_xr : r_xl;
            end else begin
                span_x0 = (w_lx <= w_rx) ? w_lx : w_rx;
                span_x1 = (w_lx <= w_rx) ? w_rx : w_lx;
            end
        end
    end

endmodule

// File: tb/tb_tri_span_gen.sv
// Directed bench for tri_span_gen with hand-computed span sequences.
module tb_tri_span_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ready = 1'b1;
    logic signed [15:0] xa = '0, ya = '0, yb = '0, xl = '0, xr = '0;
    logic signed [15:0] span_x0, span_x1, span_y;
    logic span_valid, busy, done;

    int total = 0;
    int bad = 0;
    int waited;
    int seen;

    tri_span_gen #(.COORD_WIDTH(16)) dut (
        .clk_in(clk), .rst_in(rst), .start(start),
        .xa(xa), .ya(ya), .yb(yb), .xl(xl), .xr(xr),
        .span_x0(span_x0), .span_x1(span_x1), .span_y(span_y),
        .span_valid(span_valid), .span_ready(ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a start at the current negedge; the next negedge is the INIT cycle.
    task automatic launch(input string tag, input int ax, input int ay, input int by,
                          input int lx, input int rx);
        xa = 16'(ax); ya = 16'(ay); yb = 16'(by); xl = 16'(lx); xr = 16'(rx);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_init_busy"}, int'(busy), 1);
        chk({tag, "_init_valid"}, int'(span_valid), 0);
    endtask

    // Wait (bounded) for span_valid, check fields, optionally step past the transfer.
    task automatic expect_span(input string tag, input int x0, input int x1, input int y,
                               input bit step_past, output int n);
        n = 0;
        while (span_valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, int'(span_valid), 1);
        chk({tag, "_x0"}, int'(span_x0), x0);
        chk({tag, "_x1"}, int'(span_x1), x1);
        chk({tag, "_y"}, int'(span_y), y);
        if (step_past) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(span_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_x1", int'(span_x1), 0);
        rst = 1'b0;
        @(negedge clk);

        // Apex (10,0), base y=3 from 7 to 13
        launch("t1", 10, 0, 3, 7, 13);
        expect_span("t1_s0", 10, 10, 0, 1'b1, waited);
        chk("t1_first_latency", waited, 1);
        expect_span("t1_s1", 9, 11, 1, 1'b1, waited);
        chk("t1_adv_cycles", waited, 1);
        expect_span("t1_s2", 8, 12, 2, 1'b1, waited);
        expect_span("t1_s3", 7, 13, 3, 1'b1, waited);
        chk("t1_done", int'(done), 1);
        chk("t1_busy_after", int'(busy), 0);
        @(negedge clk);
        chk("t1_done_once", int'(done), 0);
        chk("t1_idle_valid", int'(span_valid), 0);

        // Shallow edge: apex (0,0) to (8,1) needs four iterations
        launch("t2", 0, 0, 1, 0, 8);
        expect_span("t2_s0", 0, 0, 0, 1'b1, waited);
        expect_span("t2_s1", 0, 8, 1, 1'b1, waited);
        chk("t2_adv_cycles", waited, 4);
        chk("t2_done", int'(done), 1);
        @(negedge clk);

        // Degenerate triangle: ya == yb, endpoints reversed
        launch("t3", 9, 5, 5, 20, 4);
        expect_span("t3_s0", 4, 20, 5, 1'b1, waited);
        chk("t3_done", int'(done), 1);
        chk("t3_busy", int'(busy), 0);
        @(negedge clk);

        // Back-pressure on the y=1 span
        launch("t4", 10, 0, 3, 7, 13);
        expect_span("t4_s0", 10, 10, 0, 1'b1, waited);
        ready = 1'b0;
        expect_span("t4_s1", 9, 11, 1, 1'b0, waited);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", int'(span_valid), 1);
            chk("t4_hold_x0", int'(span_x0), 9);
            chk("t4_hold_x1", int'(span_x1), 11);
            chk("t4_hold_y", int'(span_y), 1);
        end
        ready = 1'b1;
        @(negedge clk);
        chk("t4_xfer", int'(span_valid), 0);
        expect_span("t4_s2", 8, 12, 2, 1'b1, waited);
        expect_span("t4_s3", 7, 13, 3, 1'b1, waited);
        chk("t4_done", int'(done), 1);
        @(negedge clk);

        // Asynchronous reset during ADVANCE
        launch("t5", 10, 0, 3, 7, 13);
        expect_span("t5_s0", 10, 10, 0, 1'b1, waited);
        chk("t5_in_adv_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_valid", int'(span_valid), 0);
        chk("t5_rst_done", int'(done), 0);
        chk("t5_rst_x0", int'(span_x0), 0);
        chk("t5_rst_y", int'(span_y), 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (span_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("t5_quiet_after_rst", seen, 0);

        // Start while busy is ignored; then done and a new start coincide
        launch("t6", 10, 0, 3, 7, 13);
        expect_span("t6_s0", 10, 10, 0, 1'b1, waited);
        xa = 16'(100); ya = 16'(-4); yb = 16'(40); xl = 16'(-30); xr = 16'(77);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expect_span("t6_s1", 9, 11, 1, 1'b1, waited);
        expect_span("t6_s2", 8, 12, 2, 1'b1, waited);
        expect_span("t6_s3", 7, 13, 3, 1'b1, waited);
        chk("t6_done", int'(done), 1);
        launch("t7", 9, 5, 5, 20, 4);
        expect_span("t7_s0", 4, 20, 5, 1'b1, waited);
        chk("t7_done", int'(done), 1);
        @(negedge clk);
        chk("t7_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tri_span_gen.md
TRI_SPAN_GEN -- requirements
Module: tri_span_gen

Interface
REQ-001 Parameter COORD_WIDTH, default 16, signed coordinate width for all x/y ports.
REQ-002 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_in  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to rasterize a flat-base triangle; ignored unless busy=0.
REQ-005 xa, ya  input  COORD_WIDTH signed each  apex vertex; sampled only on an accepted start.
REQ-006 yb  input  COORD_WIDTH signed  base scanline; sampled only on an accepted start.
REQ-007 xl, xr  input  COORD_WIDTH signed each  base endpoints in either order; sampled only on an accepted start.
REQ-008 span_x0, span_x1, span_y  output  COORD_WIDTH signed each  current span; span_x0 <= span_x1 always.
REQ-009 span_valid  output  1  span fields hold a span for the downstream 1D line drawer.
REQ-010 span_ready  input  1  downstream can take a span (driven as !busy of the 1D drawer); transfer when span_valid && span_ready.
REQ-011 busy  output  1  high from the cycle after an accepted start until the last span transfers.
REQ-012 done  output  1  one-cycle pulse in the cycle after the last span transfers.

Function
REQ-013 FSM states IDLE, INIT, EMIT, ADVANCE; IDLE->INIT on start; INIT->EMIT after one cycle; EMIT->IDLE on transfer when span_y==yb, else EMIT->ADVANCE on transfer; ADVANCE->EMIT when both edges have reached the next scanline.
REQ-014 INIT latches inputs and initializes two Bresenham edge walkers, apex->(xl,yb) and apex->(xr,yb): dx=|xe-xa|, dy=-|yb-ya|, err=dx+dy, sx/sy = sign of step, sy=+1 if yb>=ya else -1.
REQ-015 Each walker in ADVANCE does one iteration per cycle: e2=2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy; walker stops in the cycle its y changes, holding that x.
REQ-016 ADVANCE exits the cycle after both walkers have stopped; a walker already stopped holds state.
REQ-017 First span (y=ya) is xa..xa; intermediate spans use walker x values ordered min/max; the span with span_y==yb is min(xl,xr)..max(xl,xr), independent of walker x.
REQ-018 ya==yb: exactly one span, min(xl,xr)..max(xl,xr) at y=ya, then done.
REQ-019 span_valid asserted exactly in EMIT, first time two cycles after start is sampled; span fields stable while span_valid && !span_ready.
REQ-020 span_ready may be high before span_valid; no combinational path from span_ready to span_valid.
REQ-021 err registers are COORD_WIDTH+2 bits signed; e2 computed at COORD_WIDTH+3 bits; no overflow for any legal input.
REQ-022 start while busy=1 ignored, no effect on latched inputs or progress.
REQ-023 done and a new accepted start may coincide; new start enters INIT next cycle.

Reset
REQ-024 rst_in asserted, at any time including mid-ADVANCE or mid-EMIT: immediately state=IDLE, span_valid=0, busy=0, done=0, span_x0/x1/y=0, walker registers=0.
REQ-025 After rst_in deasserts, no span emitted until a new start.

Structure
REQ-026 Shared package holds the FSM state enum and the error-width constant (COORD_WIDTH+2).
REQ-027 One sub-module edge_walker (one Bresenham edge: init, step-to-next-scanline, stopped flag, x/y out), instantiated twice.

Verification
REQ-028 Apex (10,0), yb=3, xl=7, xr=13, span_ready=1 -> spans (10..10,y0),(9..11,y1),(8..12,y2),(7..13,y3); done pulse once; busy low after.
REQ-029 Apex (0,0), yb=1, xl=0, xr=8 -> spans (0..0,y0),(0..8,y1); ADVANCE lasts 4 cycles for the shallow edge.
REQ-030 ya=yb=5, xl=20, xr=4 -> single span (4..20,y5), done next cycle after transfer.
REQ-031 Case REQ-028 with span_ready low 5 cycles during EMIT of y1 -> span_valid held, fields stable at 9..11,y1, transfer on first ready cycle.
REQ-032 rst_in pulsed during ADVANCE of REQ-028 -> all outputs 0 same cycle; no spans until next start.
REQ-033 start pulsed again mid-triangle with different vertices -> ignored; spans of REQ-028 unchanged.
